// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared types and constants for the transpose job scheduler
package transpose_pkg;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] count;
        logic [11:0] length;
        logic [1:0]  d;
        logic [1:0]  r_s;
        logic        dir;
        logic [3:0]  tag;
    } job_t;

    typedef struct packed {
        logic [3:0] tag;
        logic [2:0] status;
    } cpl_t;

    localparam int JOB_W = $bits(job_t);
    localparam int CPL_W = $bits(cpl_t);

    localparam logic [2:0] CPL_OK      = 3'd0;
    localparam logic [2:0] CPL_AXI_ERR = 3'd1;
    localparam logic [2:0] CPL_RED_ERR = 3'd2;
    localparam logic [2:0] CPL_FLUSHED = 3'd3;
    localparam logic [2:0] CPL_BAD_CFG = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        FLUSH  = 2'd3
    } sched_state_t;

    // A job with nothing to move is rejected without touching the controller.
    function automatic logic job_cfg_bad(job_t j);
        return (j.count == 16'd0) || (j.length == 12'd0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty/count status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so stale entries never leak out.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/transpose_job_scheduler.sv
// rtl/transpose_job_scheduler.sv - queues transpose jobs, launches them and reports completions
module transpose_job_scheduler #(
    parameter int QDEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          job_valid_i,
    output logic                          job_ready_o,
    input  logic [31:0]                   job_src_addr_i,
    input  logic [31:0]                   job_dst_addr_i,
    input  logic [15:0]                   job_word_count_i,
    input  logic [11:0]                   job_word_length_i,
    input  logic [1:0]                    job_d_i,
    input  logic [1:0]                    job_r_s_i,
    input  logic                          job_direction_i,
    input  logic [3:0]                    job_tag_i,
    input  logic                          stop_on_error_i,
    input  logic                          irq_en_i,
    output logic                          ctrl_start_o,
    output logic [31:0]                   ctrl_src_addr_o,
    output logic [31:0]                   ctrl_dst_addr_o,
    output logic [11:0]                   ctrl_data_word_length_o,
    output logic [1:0]                    ctrl_d_o,
    output logic [1:0]                    ctrl_r_s_o,
    output logic                          ctrl_direction_o,
    output logic [15:0]                   ctrl_data_word_count_o,
    output logic [1:0]                    ctrl_status_o,
    input  logic [15:0]                   ctrl_data_word_count_i,
    input  logic [1:0]                    ctrl_status_i,
    input  logic                          ctrl_irq_i,
    input  logic                          ctrl_busy_i,
    output logic                          cpl_valid_o,
    input  logic                          cpl_ready_i,
    output logic [3:0]                    cpl_tag_o,
    output logic [2:0]                    cpl_status_o,
    output logic [$clog2(QDEPTH+1)-1:0]   pending_o,
    output logic                          busy_o,
    output logic                          irq_o
);

    import transpose_pkg::*;

    localparam int CW = $clog2(QDEPTH+1);

    sched_state_t state_q, state_d;

    job_t        job_in, job_head, cfg_q;
    cpl_t        cpl_in, cpl_head;
    logic [15:0] count_q;
    logic [1:0]  status_q;

    logic          job_push, job_pop, job_full, job_empty;
    logic [CW-1:0] job_count;
    logic          cpl_push, cpl_pop, cpl_full, cpl_empty;
    logic [CW-1:0] cpl_count;
    logic          launch_ok, head_bad, load_cfg;
    logic          unused_bits;

    always_comb begin
        job_in        = '0;
        job_in.src    = job_src_addr_i;
        job_in.dst    = job_dst_addr_i;
        job_in.count  = job_word_count_i;
        job_in.length = job_word_length_i;
        job_in.d      = job_d_i;
        job_in.r_s    = job_r_s_i;
        job_in.dir    = job_direction_i;
        job_in.tag    = job_tag_i;
    end

    assign job_ready_o = rstn_i && !job_full && (state_q != FLUSH);
    assign job_push    = job_valid_i && job_ready_o;
    assign cpl_valid_o = !cpl_empty;
    assign cpl_pop     = cpl_ready_i && cpl_valid_o;

    sync_fifo #(.WIDTH(JOB_W), .DEPTH(QDEPTH)) u_job_q (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (job_push),
        .push_data (job_in),
        .pop       (job_pop),
        .pop_data  (job_head),
        .full      (job_full),
        .empty     (job_empty),
        .count     (job_count)
    );

    sync_fifo #(.WIDTH(CPL_W), .DEPTH(QDEPTH)) u_cpl_q (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (cpl_push),
        .push_data (cpl_in),
        .pop       (cpl_pop),
        .pop_data  (cpl_head),
        .full      (cpl_full),
        .empty     (cpl_empty),
        .count     (cpl_count)
    );

    // Requiring completion space before launch guarantees the RUN-state push never drops.
    assign launch_ok = !job_empty && !cpl_full && !ctrl_busy_i;
    assign head_bad  = job_cfg_bad(job_head);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_ok && !head_bad) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (ctrl_irq_i)
                         state_d = ((status_q != 2'b00) && stop_on_error_i) ? FLUSH : IDLE;
            FLUSH:   if (job_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        job_pop       = 1'b0;
        cpl_push      = 1'b0;
        cpl_in        = '0;
        load_cfg      = 1'b0;
        ctrl_start_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    job_pop = 1'b1;
                    if (head_bad) begin
                        cpl_push      = 1'b1;
                        cpl_in.tag    = job_head.tag;
                        cpl_in.status = CPL_BAD_CFG;
                    end else begin
                        load_cfg = 1'b1;
                    end
                end
            end
            LAUNCH: ctrl_start_o = 1'b1;
            RUN: begin
                if (ctrl_irq_i) begin
                    cpl_push      = 1'b1;
                    cpl_in.tag    = cfg_q.tag;
                    cpl_in.status = {1'b0, status_q};
                end
            end
            FLUSH: begin
                if (!cpl_full && !job_empty) begin
                    job_pop       = 1'b1;
                    cpl_push      = 1'b1;
                    cpl_in.tag    = job_head.tag;
                    cpl_in.status = CPL_FLUSHED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cfg_q    <= '0;
            count_q  <= '0;
            status_q <= '0;
        end else if (load_cfg) begin
            cfg_q    <= job_head;
            count_q  <= job_head.count;
            status_q <= 2'b00;
        end else if (state_q == RUN) begin
            count_q  <= ctrl_data_word_count_i;
            status_q <= ctrl_status_i;
        end
    end

    assign ctrl_src_addr_o         = cfg_q.src;
    assign ctrl_dst_addr_o         = cfg_q.dst;
    assign ctrl_data_word_length_o = cfg_q.length;
    assign ctrl_d_o                = cfg_q.d;
    assign ctrl_r_s_o              = cfg_q.r_s;
    assign ctrl_direction_o        = cfg_q.dir;
    assign ctrl_data_word_count_o  = count_q;
    assign ctrl_status_o           = status_q;

    assign cpl_tag_o    = cpl_head.tag;
    assign cpl_status_o = cpl_head.status;
    assign pending_o    = job_count;
    assign busy_o       = (state_q != IDLE);
    assign irq_o        = irq_en_i && cpl_valid_o;

    assign unused_bits = ^{cpl_count, cfg_q.count};

endmodule
